// File: rtl/au_pkg.sv
// Shared helpers for the priority-encoder family.
// Index-width and segment-count derivations.
package au_pkg;

  function automatic int clogb2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int nseg(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

endpackage

// File: rtl/au_prio_encode_pipe_if.sv
// Stream bundle for the pipelined priority encoder.
// master drives requests and sinks results; slave is the encoder.
interface au_prio_encode_pipe_if
  import au_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int M = clogb2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic             in_msb;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_z;
  logic             out_found;
  logic             out_multi;

  modport master (
    output in_valid,
    output in_a,
    output in_msb,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_z,
    input  out_found,
    input  out_multi
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_msb,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_z,
    output out_found,
    output out_multi
  );

endinterface

// File: rtl/au_prio_encode_seg.sv
// Combinational segment encoder: any-set, local winner index
// and a two-or-more-set flag for one slice of the request vector.
module au_prio_encode_seg
  import au_pkg::*;
#(
  parameter int SEG = 8,
  localparam int MS = clogb2(SEG)
) (
  input  logic [SEG-1:0] a,
  input  logic           msb,
  output logic           any,
  output logic [MS-1:0]  idx,
  output logic           cnt2
);

  always_comb begin
    any  = 1'b0;
    cnt2 = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      cnt2 = cnt2 | (any & a[i]);
      any  = any | a[i];
    end
  end

  // Later assignments win: scan toward the preferred end.
  always_comb begin
    idx = '0;
    for (int i = 0; i < SEG; i++) begin
      if (msb && a[i])
        idx = MS'(i);
      if (!msb && a[SEG-1-i])
        idx = MS'(SEG - 1 - i);
    end
  end

endmodule

// File: rtl/au_prio_encode_pipe.sv
// Two-stage pipelined priority encoder with valid/ready streams.
// S1 encodes each segment; S2 picks the winning segment.
module au_prio_encode_pipe
  import au_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  au_prio_encode_pipe_if.slave bus
);

  localparam int M    = clogb2(WIDTH);
  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int MS   = clogb2(SEG);
  localparam int MJ   = clogb2(NSEG);
  localparam int PADW = NSEG * SEG;

  logic [PADW-1:0]          a_pad;
  logic [NSEG-1:0]          c_any;
  logic [NSEG-1:0]          c_cnt2;
  logic [NSEG-1:0][MS-1:0]  c_idx;

  logic                     s1_valid;
  logic                     s1_msb;
  logic [NSEG-1:0]          s1_any;
  logic [NSEG-1:0]          s1_cnt2;
  logic [NSEG-1:0][MS-1:0]  s1_idx;

  logic                     s2_valid;
  logic [M-1:0]             s2_z;
  logic                     s2_found;
  logic                     s2_multi;

  logic                     sel_any;
  logic                     sel_cnt2;
  logic [MJ-1:0]            js;
  logic [MS-1:0]            sel_idx;
  int                       z_full;
  logic [M-1:0]             n_z;
  logic                     n_multi;

  logic                     s2_load;
  logic                     s1_take;

  // Bits past WIDTH in the last segment read as zero.
  always_comb begin
    a_pad = '0;
    a_pad[WIDTH-1:0] = bus.in_a;
  end

  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    au_prio_encode_seg #(
      .SEG (SEG)
    ) u_seg (
      .a    (a_pad[j*SEG +: SEG]),
      .msb  (bus.in_msb),
      .any  (c_any[j]),
      .idx  (c_idx[j]),
      .cnt2 (c_cnt2[j])
    );
  end

  au_prio_encode_seg #(
    .SEG (NSEG)
  ) u_sel (
    .a    (s1_any),
    .msb  (s1_msb),
    .any  (sel_any),
    .idx  (js),
    .cnt2 (sel_cnt2)
  );

  always_comb begin
    sel_idx = '0;
    for (int j = 0; j < NSEG; j++) begin
      if (js == MJ'(j))
        sel_idx = s1_idx[j];
    end
  end

  always_comb begin
    z_full  = int'(js) * SEG + int'(sel_idx);
    n_z     = sel_any ? M'(z_full) : '0;
    n_multi = sel_cnt2 | (|s1_cnt2);
  end

  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_take = !s1_valid || s2_load;

  assign bus.in_ready  = s1_take;
  assign bus.out_valid = s2_valid;
  assign bus.out_z     = s2_z;
  assign bus.out_found = s2_found;
  assign bus.out_multi = s2_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_msb   <= 1'b0;
      s1_any   <= '0;
      s1_cnt2  <= '0;
      s1_idx   <= '0;
    end else if (s1_take) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_msb  <= bus.in_msb;
        s1_any  <= c_any;
        s1_cnt2 <= c_cnt2;
        s1_idx  <= c_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_z     <= '0;
      s2_found <= 1'b0;
      s2_multi <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_z     <= n_z;
        s2_found <= sel_any;
        s2_multi <= n_multi;
      end
    end
  end

endmodule

// File: tb/tb_au_prio_encode_pipe.sv
// Bench for au_prio_encode_pipe: scoreboard model plus literal checks.
module tb_au_prio_encode_pipe;

  typedef struct packed {
    logic [4:0] z;
    logic       f;
    logic       m;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   out_cnt;
  int   acc_cnt;
  logic rdy_dir;
  logic rnd_mode;
  logic cur_chk;
  res_t cur_r;

  res_t q[$];
  logic lchk[$];
  res_t lq[$];
  int   out_cyc[$];

  au_prio_encode_pipe_if #(.WIDTH(32)) bus ();
  au_prio_encode_pipe_if #(.WIDTH(5))  bus5 ();

  au_prio_encode_pipe #(.WIDTH(32), .SEG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  au_prio_encode_pipe #(.WIDTH(5), .SEG(2)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic res_t model(logic [31:0] a, logic m);
    res_t r;
    int   c;
    c   = $countones(a);
    r.f = (c != 0);
    r.m = (c >= 2);
    r.z = '0;
    if (m) begin
      for (int i = 0; i < 32; i++) if (a[i]) r.z = 5'(i);
    end else begin
      for (int i = 31; i >= 0; i--) if (a[i]) r.z = 5'(i);
    end
    return r;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : rdy_dir;
    end
  end

  initial begin
    logic pv, pr;
    res_t pres, e, l, act;
    logic lc;
    pv = 1'b0;
    pr = 1'b0;
    pres = '0;
    forever begin
      @(negedge clk);
      act = '{z: bus.out_z, f: bus.out_found, m: bus.out_multi};
      if (!rst_n) begin
        q.delete();
        lq.delete();
        lchk.delete();
        pv = 1'b0;
        out_cnt = 0;
        acc_cnt = 0;
      end else begin
        if (pv && !pr)
          check("stall_hold", {bus.out_valid, act}, {1'b1, pres});
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e  = q.pop_front();
            l  = lq.pop_front();
            lc = lchk.pop_front();
            check("model", act, e);
            if (lc) check("literal", act, l);
            out_cnt++;
            out_cyc.push_back(cyc);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(model(bus.in_a, bus.in_msb));
          lq.push_back(cur_r);
          lchk.push_back(cur_chk);
          acc_cnt++;
        end
        pv   = bus.out_valid;
        pr   = bus.out_ready;
        pres = act;
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic m,
                       input logic c, input res_t r);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_msb   = m;
    cur_chk      = c;
    cur_r        = r;
  endtask

  task automatic send(input logic [31:0] a, input logic m,
                      input logic c, input res_t r);
    int n;
    n = 0;
    drive(a, m, c, r);
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic [31:0] a, input logic m,
                     input int z, input logic f, input logic mu);
    send(a, m, 1'b1, '{z: 5'(z), f: f, m: mu});
  endtask

  logic [31:0] bp_a[4];
  logic        bp_m[4];
  res_t        bp_r[4];
  logic [4:0]  w5_a[4];
  logic        w5_m[4];
  logic [4:0]  w5_e[4];

  initial begin
    int n0, acc, k, d;
    logic ir, seen;
    checks = 0; failures = 0;
    rdy_dir = 1'b1; rnd_mode = 1'b0;
    cur_chk = 1'b0; cur_r = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_msb = 1'b0;
    bus5.in_valid = 1'b0; bus5.in_a = '0; bus5.in_msb = 1'b0;
    bus5.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_outs", {bus.out_z, bus.out_found, bus.out_multi}, 0);
    check("rst_in_ready", bus.in_ready, 1);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    lit(32'h0000_0020, 0, 5, 1, 0);
    lit(32'h0001_0000, 1, 16, 1, 0);
    lit(32'h0000_0000, 0, 0, 0, 0);
    lit(32'h0000_0000, 1, 0, 0, 0);
    lit(32'h0000_0300, 0, 8, 1, 1);
    lit(32'h0000_0300, 1, 9, 1, 1);
    drain();

    n0 = out_cyc.size();
    lit(32'h8000_0001, 0, 0, 1, 1);
    lit(32'h8000_0001, 1, 31, 1, 1);
    drain();
    if (out_cyc.size() >= n0 + 2)
      check("b2b_gap", out_cyc[n0+1] - out_cyc[n0], 1);
    else
      check("b2b_missing", out_cyc.size(), n0 + 2);

    bp_a = '{32'h0000_0080, 32'h0000_0100, 32'h0000_0001, 32'hF000_0000};
    bp_m = '{1'b1, 1'b0, 1'b0, 1'b0};
    bp_r = '{'{7, 1, 0}, '{8, 1, 0}, '{0, 1, 0}, '{28, 1, 1}};
    rdy_dir = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    acc = 0; k = 0;
    drive(bp_a[0], bp_m[0], 1'b1, bp_r[0]);
    repeat (8) begin
      @(negedge clk);
      ir = bus.in_ready;
      @(posedge clk);
      #1;
      if (ir) begin
        acc++;
        k++;
        if (k < 4) drive(bp_a[k], bp_m[k], 1'b1, bp_r[k]);
      end
    end
    @(negedge clk);
    check("bp_accepted", acc, 2);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_hold", {bus.out_valid, bus.out_z}, {1'b1, 5'd7});
    n0 = out_cnt;
    rdy_dir = 1'b1;
    for (int i = k; i < 4; i++) send(bp_a[i], bp_m[i], 1'b1, bp_r[i]);
    drain();
    check("bp_count", out_cnt - n0, 4);

    rdy_dir = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    lit(32'h0000_0020, 0, 5, 1, 0);
    lit(32'h0000_0300, 1, 9, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", bus.out_valid, 0);
    check("rst_async_ready", bus.in_ready, 1);
    rdy_dir = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_no_stale", seen, 0);
    @(posedge clk);
    #1;

    w5_a = '{5'b10000, 5'b00101, 5'b00101, 5'b00000};
    w5_m = '{1'b0, 1'b1, 1'b0, 1'b1};
    w5_e = '{5'b10010, 5'b01011, 5'b00011, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      bus5.in_valid = 1'b1;
      bus5.in_a     = w5_a[i];
      bus5.in_msb   = w5_m[i];
      @(posedge clk);
      #1;
      bus5.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("w5_result",
            {bus5.out_valid, bus5.out_z, bus5.out_found, bus5.out_multi},
            {1'b1, w5_e[i]});
    end

    rnd_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a;
      d = int'($urandom_range(0, 4));
      case (d)
        0: a = '0;
        1: a = 32'h1 << $urandom_range(0, 31);
        2: a = (32'h1 << $urandom_range(0, 31)) |
               (32'h1 << $urandom_range(0, 31));
        3: a = $urandom;
        default: a = $urandom & $urandom & $urandom;
      endcase
      send(a, 1'($urandom_range(0, 1)), 1'b0, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    drain();
    check("final_queue_empty", q.size(), 0);
    check("final_in_out_count", out_cnt, acc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
